// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: flags the single disagreeing TMR replica after a run of
// mismatches, requests lane recovery, and counts voter-error cycles.
module tmr_fault_monitor #(
  parameter int WIDTH       = 27,
  parameter int FAIL_THRESH = 4,
  parameter int HOLDOFF     = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic [WIDTH-1:0] data_C,
  input  logic             TMR_error,
  input  logic             recov_ack,
  input  logic             clear,
  output logic [2:0]       lane_fault,
  output logic             recov_req,
  output logic [1:0]       recov_lane,
  output logic [CNT_W-1:0] err_count,
  output logic             multi_fault
);
  typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;
  localparam logic [7:0] THR = 8'(FAIL_THRESH);
  state_t           state_q, state_d;
  logic [2:0][7:0]  cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic [2:0]       lf_q, lf_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             mf_q, mf_d;
  logic             mab, mbc, mac, trip, rec;
  logic [2:0]       mis;
  assign mab  = data_A != data_B;
  assign mbc  = data_B != data_C;
  assign mac  = data_A != data_C;
  assign trip = mab & mbc & mac;
  assign mis  = {mac & mbc & !mab, mab & mbc & !mac, mab & mac & !mbc};
  assign rec  = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lane_d  = lane_q;
    lf_d    = lf_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = (rec && lane_q == 2'(i)) ? 8'd0 :
                 mis[i] ? ((cnt_q[i] == THR) ? cnt_q[i] : cnt_q[i] + 8'd1) :
                 trip ? cnt_q[i] : 8'd0;
      if (cnt_d[i] == THR && cnt_q[i] != THR) lf_d[i] = 1'b1;
    end
    case (state_q)
      IDLE: if (|lf_q) begin
        lane_d  = lf_q[0] ? 2'd0 : lf_q[1] ? 2'd1 : 2'd2;
        state_d = REQ;
      end
      REQ: if (recov_ack) begin
        state_d = SETTLE;
        hold_d  = 8'(HOLDOFF);
      end
      SETTLE: begin
        hold_d = hold_q - 8'd1;
        if (hold_q == 8'd1) begin
          lf_d[lane_q] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = clear ? '0 : (TMR_error && !(&err_q)) ? err_q + 1'b1 : err_q;
    mf_d  = clear ? 1'b0 : trip ? 1'b1 : mf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      lf_q    <= '0;
      lane_q  <= '0;
      err_q   <= '0;
      mf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      lf_q    <= lf_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
      mf_q    <= mf_d;
    end
  end
  assign lane_fault  = lf_q;
  assign recov_req   = state_q == REQ;
  assign recov_lane  = lane_q;
  assign err_count   = err_q;
  assign multi_fault = mf_q;
endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb_tmr_fault_monitor: table-driven scoreboard bench for tmr_fault_monitor.
module tb_tmr_fault_monitor;
  localparam int W = 27;
  localparam logic [W-1:0] BASE = 27'h1234567;
  localparam logic [2:0] EQ = 0, PA = 1, PB = 2, PC = 3, PT = 4;
  typedef struct {
    logic [2:0]  lf;
    logic        req;
    logic [1:0]  lane;
    logic        mf;
    logic [15:0] ec;
  } exp_t;
  typedef struct {
    int         n;
    logic       rst;
    logic [2:0] pat;
    logic       terr, ack, clr;
    exp_t       e;
  } vec_t;
  logic clk = 0, rst = 1, terr = 0, ack = 0, clr = 0;
  logic [2:0] pat = EQ;
  logic [W-1:0] data_A, data_B, data_C;
  logic [2:0] lane_fault;
  logic recov_req, multi_fault;
  logic [1:0] recov_lane;
  logic [15:0] err_count;
  int checks = 0, fails = 0;
  exp_t sb[$];
  vec_t tbl[$];
  always #5 clk = ~clk;
  assign data_A = (pat == PA) ? ~BASE : BASE;
  assign data_B = (pat == PB || pat == PT) ? ~BASE : BASE;
  assign data_C = (pat == PC) ? ~BASE : (pat == PT) ? (BASE ^ 27'h1) : BASE;
  tmr_fault_monitor dut (
    .clk(clk), .rst(rst), .data_A(data_A), .data_B(data_B), .data_C(data_C),
    .TMR_error(terr), .recov_ack(ack), .clear(clr), .lane_fault(lane_fault),
    .recov_req(recov_req), .recov_lane(recov_lane), .err_count(err_count),
    .multi_fault(multi_fault)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (sb.size() > 0) begin
    exp_t e;
    e = sb.pop_front();
    chk("lane_fault", 16'(lane_fault), 16'(e.lf));
    chk("recov_req", 16'(recov_req), 16'(e.req));
    chk("recov_lane", 16'(recov_lane), 16'(e.lane));
    chk("multi_fault", 16'(multi_fault), 16'(e.mf));
    chk("err_count", err_count, e.ec);
  end
  task automatic apply(input logic r, input logic [2:0] p, input logic t, input logic a,
                       input logic c, input exp_t e);
    rst = r; pat = p; terr = t; ack = a; clr = c;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask
  function automatic vec_t mk(input int n, input logic r, input logic [2:0] p, input logic t,
                              input logic a, input logic c, input logic [2:0] lf, input logic q,
                              input logic [1:0] ln, input logic mf, input logic [15:0] ec);
    vec_t v;
    v.n = n; v.rst = r; v.pat = p; v.terr = t; v.ack = a; v.clr = c;
    v.e.lf = lf; v.e.req = q; v.e.lane = ln; v.e.mf = mf; v.e.ec = ec;
    return v;
  endfunction
  initial begin
    exp_t e;
    tbl.push_back(mk(2, 1, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(20, 0, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, PA, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, PA, 0, 0, 0, 3'b001, 0, 0, 0, 0));
    tbl.push_back(mk(6, 0, EQ, 0, 0, 0, 3'b001, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 1, 0, 3'b001, 0, 0, 0, 0));
    tbl.push_back(mk(7, 0, EQ, 0, 1, 0, 3'b001, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, PB, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, PB, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, PC, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, PC, 0, 0, 0, 3'b100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 0, 3'b100, 1, 2, 0, 0));
    tbl.push_back(mk(2, 0, PC, 0, 0, 0, 3'b100, 1, 2, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 1, 0, 3'b100, 0, 2, 0, 0));
    tbl.push_back(mk(3, 0, PA, 0, 0, 0, 3'b100, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, PA, 0, 0, 0, 3'b101, 0, 2, 0, 0));
    tbl.push_back(mk(3, 0, EQ, 0, 0, 0, 3'b101, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 0, 3'b001, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 0, 3'b001, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 1, 0, 3'b001, 0, 0, 0, 0));
    tbl.push_back(mk(7, 0, EQ, 0, 1, 0, 3'b001, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, EQ, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, PB, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, PT, 0, 0, 0, 3'b000, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, PB, 0, 0, 0, 3'b000, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, PB, 0, 0, 0, 3'b010, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 0, 3'b010, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 1, 3'b010, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, EQ, 1, 0, 0, 3'b000, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, EQ, 1, 0, 0, 3'b000, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, EQ, 1, 0, 1, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, EQ, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    foreach (tbl[k])
      for (int r = 0; r < tbl[k].n; r++)
        apply(tbl[k].rst, tbl[k].pat, tbl[k].terr, tbl[k].ack, tbl[k].clr, tbl[k].e);
    e.lf = 0; e.req = 0; e.lane = 0; e.mf = 0;
    for (int i = 1; i <= 70000; i++) begin
      e.ec = (i > 65535) ? 16'hFFFF : 16'(i);
      apply(0, EQ, 1, 0, 0, e);
    end
    e.ec = 0;
    apply(0, EQ, 1, 0, 1, e);
    e.ec = 1;
    apply(0, EQ, 1, 0, 0, e);
    apply(0, EQ, 0, 0, 0, e);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
